ball_trajectory_predictor: RTL and testbench



---
 rtl/ball_track_pkg.sv | 24 ++
 rtl/ball_extrapolator.sv | 87 ++++++++
 rtl/ball_trajectory_predictor.sv | 218 +++++++++++++++++++++
 tb/tb_ball_trajectory_predictor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ball_track_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ball_track_pkg
// Brief    : Shared types and grid constants for the ball tracking pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package ball_track_pkg;

    localparam int COLS       = 40;
    localparam int ROWS       = 30;
    localparam int BLOCK_SIZE = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQ     = 2'd1,
        ST_TRACK   = 2'd2,
        ST_PREDICT = 2'd3
    } state_t;

    typedef logic signed [6:0] vel_t;
    typedef logic [5:0]        grid_t;

endpackage
`default_nettype wire

// File: rtl/ball_extrapolator.sv
`default_nettype none
// ============================================================================
// Module   : ball_extrapolator
// Brief    : Steps the ball one frame-delta per cycle towards the paddle row,
//            mirroring off the side walls. done/hit are combinational for the
//            step being computed so the owner can register the result on the
//            same edge that commits the step.
// Revision : 1.0 - initial release
// ============================================================================
module ball_extrapolator
    import ball_track_pkg::*;
#(
    parameter int PADDLE_ROW = 28,
    parameter int MAX_STEPS  = 32
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  grid_t start_x,
    input  grid_t start_y,
    input  vel_t  start_vx,
    input  vel_t  start_vy,
    output logic  done,
    output logic  hit,
    output grid_t hit_x
);

    localparam int STEP_W = $clog2(MAX_STEPS + 1);
    localparam logic signed [7:0] X_MAX  = 8'(COLS - 1);
    localparam logic signed [7:0] X_FOLD = 8'(2 * (COLS - 1));
    localparam logic signed [7:0] Y_HIT  = 8'(PADDLE_ROW);

    logic                busy;
    logic signed [7:0]   px, py, vx, vy;
    logic [STEP_W-1:0]   step;

    logic signed [7:0]   sum_x, sum_y, nx, nvx;
    logic [STEP_W-1:0]   step_nx;

    // Next position with wall reflection and termination decode.
    always_comb begin
        sum_x   = px + vx;
        sum_y   = py + vy;
        step_nx = step + 1'b1;
        nx      = sum_x;
        nvx     = vx;
        if (sum_x < 8'sd0) begin
            nx  = -sum_x;
            nvx = -vx;
        end else if (sum_x > X_MAX) begin
            nx  = X_FOLD - sum_x;
            nvx = -vx;
        end
        hit   = busy && (sum_y >= Y_HIT);
        done  = busy && ((sum_y >= Y_HIT) || (step_nx == STEP_W'(MAX_STEPS)));
        hit_x = nx[5:0];
    end

    // Load on start, then commit one step per cycle until done.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            px   <= '0;
            py   <= '0;
            vx   <= '0;
            vy   <= '0;
            step <= '0;
        end else if (start) begin
            busy <= 1'b1;
            px   <= {2'b00, start_x};
            py   <= {2'b00, start_y};
            vx   <= {start_vx[6], start_vx};
            vy   <= {start_vy[6], start_vy};
            step <= '0;
        end else if (busy) begin
            px   <= nx;
            py   <= sum_y;
            vx   <= nvx;
            step <= step_nx;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ball_trajectory_predictor.sv
`default_nettype none
// ============================================================================
// Module   : ball_trajectory_predictor
// Brief    : Locks onto the per-frame ball grid position, derives velocity,
//            and predicts the column where the ball reaches the paddle row.
//            Result delivered over a valid/ready handshake (latest wins).
// Options  : VEL_AVG_EN - TRACK velocity is the average of the latest two
//            accepted deltas instead of the raw latest delta.
// Revision : 1.0 - initial release
// ============================================================================
module ball_trajectory_predictor
    import ball_track_pkg::*;
#(
    parameter int PADDLE_ROW = 28,
    parameter int MAX_JUMP   = 6,
    parameter int ACQ_FRAMES = 2,
    parameter int MISS_LIMIT = 4,
    parameter int MAX_STEPS  = 32
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       FRAME_TICK,
    input  logic [5:0] BALL_X,
    input  logic [5:0] BALL_Y,
    input  logic       TARGET_READY,
    output logic [5:0] TARGET_X,
    output logic       TARGET_VALID,
    output logic [6:0] VEL_X,
    output logic [6:0] VEL_Y,
    output logic       LOCKED,
    output logic [1:0] STATE
);

    localparam vel_t JUMP_LIM = 7'(MAX_JUMP);

    state_t     state, state_nx;
    grid_t      pos_x, pos_y, pos_x_nx, pos_y_nx;
    vel_t       vel_x, vel_y, vel_x_nx, vel_y_nx;
    logic [2:0] acq_cnt, acq_cnt_nx, miss_cnt, miss_cnt_nx;
    vel_t       dx, dy, vel_trk_x, vel_trk_y;
    logic       in_range, accept;
    logic       ext_start, ext_done, ext_hit;
    grid_t      ext_hit_x;
    logic       target_valid;
    grid_t      target_x;

`ifdef VEL_AVG_EN
    vel_t              d_prev_x, d_prev_y, d_prev_x_nx, d_prev_y_nx;
    logic signed [7:0] avg_x, avg_y;

    // Two-sample average of the frame delta, arithmetic halving.
    always_comb begin
        avg_x     = (8'(dx) + 8'(d_prev_x)) >>> 1;
        avg_y     = (8'(dy) + 8'(d_prev_y)) >>> 1;
        vel_trk_x = avg_x[6:0];
        vel_trk_y = avg_y[6:0];
    end
`else
    assign vel_trk_x = dx;
    assign vel_trk_y = dy;
`endif

    // Deltas against the tracked position and plausibility test.
    always_comb begin
        dx       = $signed({1'b0, BALL_X}) - $signed({1'b0, pos_x});
        dy       = $signed({1'b0, BALL_Y}) - $signed({1'b0, pos_y});
        in_range = (BALL_X < 6'(COLS)) && (BALL_Y < 6'(ROWS));
        accept   = in_range && (dx <= JUMP_LIM) && (dx >= -JUMP_LIM)
                            && (dy <= JUMP_LIM) && (dy >= -JUMP_LIM);
    end

    // Next-state and tracking-register updates.
    always_comb begin
        state_nx    = state;
        pos_x_nx    = pos_x;
        pos_y_nx    = pos_y;
        vel_x_nx    = vel_x;
        vel_y_nx    = vel_y;
        acq_cnt_nx  = acq_cnt;
        miss_cnt_nx = miss_cnt;
        ext_start   = 1'b0;
`ifdef VEL_AVG_EN
        d_prev_x_nx = d_prev_x;
        d_prev_y_nx = d_prev_y;
`endif
        case (state)
            ST_IDLE: begin
                if (FRAME_TICK && in_range) begin
                    pos_x_nx   = BALL_X;
                    pos_y_nx   = BALL_Y;
                    acq_cnt_nx = 3'd1;
                    state_nx   = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (FRAME_TICK) begin
                    pos_x_nx = BALL_X;
                    pos_y_nx = BALL_Y;
                    if (accept) begin
                        vel_x_nx   = dx;
                        vel_y_nx   = dy;
                        acq_cnt_nx = acq_cnt + 3'd1;
`ifdef VEL_AVG_EN
                        d_prev_x_nx = dx;
                        d_prev_y_nx = dy;
`endif
                        if ((acq_cnt + 3'd1) >= 3'(ACQ_FRAMES)) begin
                            miss_cnt_nx = 3'd0;
                            state_nx    = ST_TRACK;
                        end
                    end else begin
                        acq_cnt_nx = 3'd1;
                    end
                end
            end
            ST_TRACK: begin
                if (FRAME_TICK) begin
                    if (accept) begin
                        vel_x_nx    = vel_trk_x;
                        vel_y_nx    = vel_trk_y;
                        pos_x_nx    = BALL_X;
                        pos_y_nx    = BALL_Y;
                        miss_cnt_nx = 3'd0;
`ifdef VEL_AVG_EN
                        d_prev_x_nx = dx;
                        d_prev_y_nx = dy;
`endif
                        if (vel_trk_y > 7'sd0) begin
                            ext_start = 1'b1;
                            state_nx  = ST_PREDICT;
                        end
                    end else begin
                        miss_cnt_nx = miss_cnt + 3'd1;
                        if ((miss_cnt + 3'd1) == 3'(MISS_LIMIT)) begin
                            vel_x_nx = '0;
                            vel_y_nx = '0;
                            state_nx = ST_IDLE;
                        end
                    end
                end
            end
            ST_PREDICT: begin
                // Frame ticks are ignored here; the walk ends within MAX_STEPS.
                if (ext_done) begin
                    state_nx = ST_TRACK;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State and tracking registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            pos_x    <= '0;
            pos_y    <= '0;
            vel_x    <= '0;
            vel_y    <= '0;
            acq_cnt  <= '0;
            miss_cnt <= '0;
`ifdef VEL_AVG_EN
            d_prev_x <= '0;
            d_prev_y <= '0;
`endif
        end else begin
            state    <= state_nx;
            pos_x    <= pos_x_nx;
            pos_y    <= pos_y_nx;
            vel_x    <= vel_x_nx;
            vel_y    <= vel_y_nx;
            acq_cnt  <= acq_cnt_nx;
            miss_cnt <= miss_cnt_nx;
`ifdef VEL_AVG_EN
            d_prev_x <= d_prev_x_nx;
            d_prev_y <= d_prev_y_nx;
`endif
        end
    end

    ball_extrapolator #(
        .PADDLE_ROW (PADDLE_ROW),
        .MAX_STEPS  (MAX_STEPS)
    ) u_extrap (
        .clk      (CLK),
        .rst      (RST),
        .start    (ext_start),
        .start_x  (BALL_X),
        .start_y  (BALL_Y),
        .start_vx (vel_trk_x),
        .start_vy (vel_trk_y),
        .done     (ext_done),
        .hit      (ext_hit),
        .hit_x    (ext_hit_x)
    );

    // Result holding register: a new hit always wins over a pending accept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            target_valid <= 1'b0;
            target_x     <= '0;
        end else if (ext_hit) begin
            target_valid <= 1'b1;
            target_x     <= ext_hit_x;
        end else if (target_valid && TARGET_READY) begin
            target_valid <= 1'b0;
        end
    end

    assign TARGET_X     = target_x;
    assign TARGET_VALID = target_valid;
    assign VEL_X        = vel_x;
    assign VEL_Y        = vel_y;
    assign LOCKED       = (state == ST_TRACK) || (state == ST_PREDICT);
    assign STATE        = state;

endmodule
`default_nettype wire

// File: tb/tb_ball_trajectory_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball_trajectory_predictor
// Brief    : Directed self-checking bench for ball_trajectory_predictor
//            (default build, raw-delta velocity).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ball_trajectory_predictor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [5:0] ball_x = '0;
    logic [5:0] ball_y = '0;
    logic       target_ready = 1'b1;
    logic [5:0] target_x;
    logic       target_valid;
    logic [6:0] vel_x;
    logic [6:0] vel_y;
    logic       locked;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    ball_trajectory_predictor dut (
        .CLK          (clk),
        .RST          (rst),
        .FRAME_TICK   (frame_tick),
        .BALL_X       (ball_x),
        .BALL_Y       (ball_y),
        .TARGET_READY (target_ready),
        .TARGET_X     (target_x),
        .TARGET_VALID (target_valid),
        .VEL_X        (vel_x),
        .VEL_Y        (vel_y),
        .LOCKED       (locked),
        .STATE        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One-cycle FRAME_TICK; returns at the negedge after the sampling edge.
    task automatic frame(input logic [5:0] x, input logic [5:0] y);
        ball_x     = x;
        ball_y     = y;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_state",  state,        2'd0);
        chk("rst_valid",  target_valid, 1'b0);
        chk("rst_locked", locked,       1'b0);
        chk("rst_velx",   vel_x,        7'd0);
        chk("rst_tx",     target_x,     6'd0);
        rst = 1'b0;

        // Basic lock and straight prediction, 7 steps -> 38
        target_ready = 1'b1;
        frame(6'd20, 6'd10);
        chk("acq_state", state, 2'd1);
        frame(6'd22, 6'd12);
        chk("lock_locked", locked, 1'b1);
        chk("lock_state",  state,  2'd2);
        chk("lock_velx",   vel_x,  7'd2);
        chk("lock_vely",   vel_y,  7'd2);
        frame(6'd24, 6'd14);
        chk("pred_state", state, 2'd3);
        cycles(6);
        chk("pred_early_valid", target_valid, 1'b0);
        cycles(1);
        chk("pred_valid", target_valid, 1'b1);
        chk("pred_tx",    target_x,     6'd38);
        chk("pred_back",  state,        2'd2);
        cycles(1);
        chk("pred_pulse", target_valid, 1'b0);

        // Right-wall reflection -> 12
        do_reset();
        frame(6'd30, 6'd10);
        frame(6'd34, 6'd12);
        chk("refl_velx", vel_x, 7'd4);
        frame(6'd38, 6'd14);
        cycles(6);
        chk("refl_early", target_valid, 1'b0);
        cycles(1);
        chk("refl_valid", target_valid, 1'b1);
        chk("refl_tx",    target_x,     6'd12);

        // Loss of lock after four misses
        do_reset();
        frame(6'd20, 6'd16);
        frame(6'd20, 6'd14);
        chk("miss_lock", state, 2'd2);
        chk("miss_vely", vel_y, 7'h7E);
        frame(6'd5, 6'd0);
        frame(6'd5, 6'd0);
        frame(6'd5, 6'd0);
        chk("miss3_state", state, 2'd2);
        chk("miss3_vely",  vel_y, 7'h7E);
        frame(6'd5, 6'd0);
        chk("miss4_state", state,        2'd0);
        chk("miss4_velx",  vel_x,        7'd0);
        chk("miss4_vely",  vel_y,        7'd0);
        chk("miss4_valid", target_valid, 1'b0);

        // Upward velocity: no prediction
        do_reset();
        frame(6'd20, 6'd15);
        frame(6'd21, 6'd14);
        frame(6'd22, 6'd13);
        chk("up_state", state, 2'd2);
        chk("up_vely",  vel_y, 7'h7F);
        chk("up_velx",  vel_x, 7'd1);
        cycles(3);
        chk("up_hold",  state,        2'd2);
        chk("up_valid", target_valid, 1'b0);

        // Out-of-grid sample is rejected even when within jump distance
        do_reset();
        frame(6'd37, 6'd20);
        frame(6'd39, 6'd21);
        frame(6'd40, 6'd20);
        chk("oob_velx",  vel_x, 7'd2);
        chk("oob_vely",  vel_y, 7'd1);
        chk("oob_state", state, 2'd2);

        // Back-pressure: two results, latest wins, one-cycle accept
        do_reset();
        target_ready = 1'b0;
        frame(6'd20, 6'd10);
        frame(6'd22, 6'd12);
        frame(6'd24, 6'd14);
        cycles(7);
        chk("bp_valid1", target_valid, 1'b1);
        chk("bp_tx1",    target_x,     6'd38);
        frame(6'd27, 6'd18);
        chk("bp_hold_state", state, 2'd3);
        cycles(2);
        chk("bp_hold_valid", target_valid, 1'b1);
        chk("bp_hold_tx",    target_x,     6'd38);
        cycles(1);
        chk("bp_valid2", target_valid, 1'b1);
        chk("bp_tx2",    target_x,     6'd36);
        cycles(2);
        chk("bp_stuck", target_valid, 1'b1);
        target_ready = 1'b1;
        @(negedge clk);
        target_ready = 1'b0;
        chk("bp_cleared", target_valid, 1'b0);

        // Reset in the middle of a prediction
        target_ready = 1'b1;
        do_reset();
        frame(6'd20, 6'd10);
        frame(6'd22, 6'd12);
        frame(6'd24, 6'd14);
        cycles(2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_state",  state,        2'd0);
        chk("mid_rst_valid",  target_valid, 1'b0);
        chk("mid_rst_locked", locked,       1'b0);
        rst = 1'b0;
        cycles(8);
        chk("mid_rst_noout", target_valid, 1'b0);
        frame(6'd20, 6'd10);
        chk("mid_rst_reacq", state, 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
